// File: rtl/reset_pkg.sv
// Shared FSM state encoding, reset-cause codes and
// helpers for the reset sequencer.
package reset_pkg;

    typedef logic [2:0] state_t;
    typedef logic [1:0] cause_t;

    localparam state_t ST_POR          = 3'd0;
    localparam state_t ST_RUN          = 3'd1;
    localparam state_t ST_DEBOUNCE     = 3'd2;
    localparam state_t ST_HOLD         = 3'd3;
    localparam state_t ST_WAIT_RELEASE = 3'd4;

    localparam cause_t CAUSE_POR    = 2'd0;
    localparam cause_t CAUSE_BUTTON = 2'd1;
    localparam cause_t CAUSE_SW     = 2'd2;

    function automatic int max3(
        input int a,
        input int b,
        input int c
    );
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    function automatic logic [7:0] sat_inc8(
        input logic [7:0] v
    );
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/sync_bit.sv
// Two-flop synchronizer for a single asynchronous bit,
// with a parameterized reset value.
module sync_bit #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;

    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/reset_seq.sv
// Reset sequencer: power-on stretch, debounced button
// and software resets, all sharing one counter.
module reset_seq
    import reset_pkg::*;
#(
    parameter int POR_CYCLES      = 1024,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int HOLD_CYCLES     = 256
) (
    input  logic       clk,
    input  logic       reset_,
    input  logic       button_,
    input  logic       sw_reset_req,
    output logic       reset_out_,
    output logic [1:0] reset_cause,
    output logic [7:0] reset_count
);

    localparam int CNT_MAX =
        max3(POR_CYCLES, DEBOUNCE_CYCLES, HOLD_CYCLES);
    localparam int CNT_W = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] POR_LAST =
        CNT_W'(POR_CYCLES - 1);
    localparam logic [CNT_W-1:0] DEB_LAST =
        CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST =
        CNT_W'(HOLD_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic btn_s;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             rout_q, rout_d;
    cause_t           cause_q, cause_d;
    logic [7:0]       count_q, count_d;

    logic   hold_go;
    cause_t hold_cause;

    sync_bit #(
        .RESET_VAL(1'b1)
    ) u_btn_sync (
        .clk  (clk),
        .rst_n(reset_),
        .d    (button_),
        .q    (btn_s)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rout_d     = rout_q;
        cause_d    = cause_q;
        count_d    = count_q;
        hold_go    = 1'b0;
        hold_cause = CAUSE_SW;

        unique case (state_q)
            ST_POR: begin
                rout_d = 1'b0;
                if (cnt_q == POR_LAST) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                    rout_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_RUN: begin
                rout_d = 1'b1;
                if (sw_reset_req) begin
                    hold_go    = 1'b1;
                    hold_cause = CAUSE_SW;
                end else if (!btn_s) begin
                    state_d = ST_DEBOUNCE;
                    cnt_d   = CNT_ONE;
                end
            end
            ST_DEBOUNCE: begin
                rout_d = 1'b1;
                // software request outranks a completing debounce
                if (sw_reset_req) begin
                    hold_go    = 1'b1;
                    hold_cause = CAUSE_SW;
                end else if (btn_s) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end else if (cnt_q == DEB_LAST) begin
                    hold_go    = 1'b1;
                    hold_cause = CAUSE_BUTTON;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_HOLD: begin
                rout_d = 1'b0;
                if (cnt_q == HOLD_LAST) begin
                    cnt_d = '0;
                    if (btn_s) begin
                        state_d = ST_RUN;
                        rout_d  = 1'b1;
                    end else begin
                        state_d = ST_WAIT_RELEASE;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_WAIT_RELEASE: begin
                rout_d = 1'b0;
                if (btn_s) begin
                    state_d = ST_RUN;
                    rout_d  = 1'b1;
                end
            end
            default: begin
                state_d = ST_POR;
                cnt_d   = '0;
                rout_d  = 1'b0;
            end
        endcase

        // entry edge of HOLD counts as its first low cycle
        if (hold_go) begin
            state_d = ST_HOLD;
            cnt_d   = CNT_ONE;
            rout_d  = 1'b0;
            cause_d = hold_cause;
            count_d = sat_inc8(count_q);
        end
    end

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            state_q <= ST_POR;
            cnt_q   <= '0;
            rout_q  <= 1'b0;
            cause_q <= CAUSE_POR;
            count_q <= 8'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rout_q  <= rout_d;
            cause_q <= cause_d;
            count_q <= count_d;
        end
    end

    assign reset_out_  = rout_q;
    assign reset_cause = cause_q;
    assign reset_count = count_q;

endmodule

// File: tb/tb_reset_seq.sv
// Directed bench for reset_seq with small cycle counts
// (POR 8, debounce 4, hold 5).
module tb_reset_seq;

    logic       clk;
    logic       reset_;
    logic       button_;
    logic       sw_reset_req;
    logic       reset_out_;
    logic [1:0] reset_cause;
    logic [7:0] reset_count;

    int n_vec;
    int n_err;

    reset_seq #(
        .POR_CYCLES     (8),
        .DEBOUNCE_CYCLES(4),
        .HOLD_CYCLES    (5)
    ) dut (
        .clk         (clk),
        .reset_      (reset_),
        .button_     (button_),
        .sw_reset_req(sw_reset_req),
        .reset_out_  (reset_out_),
        .reset_cause (reset_cause),
        .reset_count (reset_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(
        input string       tag,
        input logic [31:0] got,
        input logic [31:0] exp
    );
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d",
                     tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic por_check(input string tag);
        for (int e = 1; e <= 8; e++) begin
            tick();
            chk($sformatf("%s_e%0d", tag, e),
                32'(reset_out_), (e == 8) ? 1 : 0);
        end
    endtask

    initial begin
        n_vec        = 0;
        n_err        = 0;
        reset_       = 1'b0;
        button_      = 1'b1;
        sw_reset_req = 1'b0;

        // held in reset
        repeat (3) tick();
        chk("rst_out", 32'(reset_out_), 0);
        chk("rst_cause", 32'(reset_cause), 0);
        chk("rst_count", 32'(reset_count), 0);

        // power-on sequence
        reset_ = 1'b1;
        por_check("por");
        chk("por_cause", 32'(reset_cause), 0);
        chk("por_count", 32'(reset_count), 0);

        // short button glitch is rejected
        button_ = 1'b0;
        tick();
        tick();
        button_ = 1'b1;
        for (int e = 3; e <= 8; e++) begin
            tick();
            chk($sformatf("glitch_e%0d", e),
                32'(reset_out_), 1);
        end
        chk("glitch_count", 32'(reset_count), 0);

        // long press: low e6..e12, high e13
        button_ = 1'b0;
        for (int e = 1; e <= 14; e++) begin
            tick();
            if (e == 10) button_ = 1'b1;
            chk($sformatf("btn_e%0d", e), 32'(reset_out_),
                (e >= 6 && e <= 12) ? 0 : 1);
            if (e == 6) begin
                chk("btn_cause", 32'(reset_cause), 1);
                chk("btn_count", 32'(reset_count), 1);
            end
        end

        // sw pulse, second pulse inside HOLD ignored
        for (int e = 1; e <= 7; e++) begin
            sw_reset_req = (e == 1 || e == 3);
            tick();
            sw_reset_req = 1'b0;
            chk($sformatf("sw_e%0d", e), 32'(reset_out_),
                (e <= 5) ? 0 : 1);
        end
        chk("sw_cause", 32'(reset_cause), 2);
        chk("sw_count", 32'(reset_count), 2);

        // sw on the edge the debounce would complete
        button_ = 1'b0;
        for (int e = 1; e <= 14; e++) begin
            sw_reset_req = (e == 6);
            tick();
            sw_reset_req = 1'b0;
            if (e == 6) button_ = 1'b1;
            chk($sformatf("race_e%0d", e), 32'(reset_out_),
                (e >= 6 && e <= 10) ? 0 : 1);
        end
        chk("race_cause", 32'(reset_cause), 2);
        chk("race_count", 32'(reset_count), 3);

        // drive the count past 255
        for (int p = 0; p < 260; p++) begin
            sw_reset_req = 1'b1;
            tick();
            sw_reset_req = 1'b0;
            repeat (6) tick();
        end
        chk("sat_count", 32'(reset_count), 255);
        chk("sat_out", 32'(reset_out_), 1);

        // async reset in the middle of HOLD
        sw_reset_req = 1'b1;
        tick();
        sw_reset_req = 1'b0;
        tick();
        chk("mid_hold_out", 32'(reset_out_), 0);
        #2 reset_ = 1'b0;
        #1;
        chk("abort_out", 32'(reset_out_), 0);
        chk("abort_cause", 32'(reset_cause), 0);
        chk("abort_count", 32'(reset_count), 0);
        #1 reset_ = 1'b1;
        por_check("repor");

        // async reset from RUN drops output with no edge
        #2 reset_ = 1'b0;
        #1;
        chk("async_out", 32'(reset_out_), 0);
        #1 reset_ = 1'b1;
        por_check("por3");

        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/reset_seq.md
RESET_SEQ -- requirements
Module: reset_seq

Interface
REQ-001 SHALL have parameter POR_CYCLES, default 1024: reset_out_ low time after power-on/reset_ release, in clk cycles; legal range 2..65535.
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 50000: cycles button_ must stay pressed to be accepted; legal range 2..2^20-1.
REQ-003 SHALL have parameter HOLD_CYCLES, default 256: minimum reset_out_ low time for button/software resets; legal range 2..65535.
REQ-004 SHALL have port clk  input  1  sole clock.
REQ-005 SHALL have port reset_  input  1  asynchronous active-low reset (e.g. PLL lock); asserts without clk.
REQ-006 SHALL have port button_  input  1  raw asynchronous pushbutton, low = pressed.
REQ-007 SHALL have port sw_reset_req  input  1  clk-synchronous single-cycle software reset request.
REQ-008 SHALL have port reset_out_  output  1  active-low sequenced reset to the downstream synchronizer, driven directly from a flop.
REQ-009 SHALL have port reset_cause  output  2  last reset cause: 0 = POR, 1 = button, 2 = software, 3 never driven.
REQ-010 SHALL have port reset_count  output  8  saturating count of button/software resets since last reset_ assertion.

Function
REQ-011 SHALL implement FSM states POR, RUN, DEBOUNCE, HOLD, WAIT_RELEASE.
REQ-012 SHALL synchronize button_ through two flops (btn_s); btn_s lags button_ by 2 clk edges.
REQ-013 POR: reset_out_ low; counter counts clk edges; on edge POR_CYCLES after reset_ deassertion (first edge = 1), go to RUN and drive reset_out_ high.
REQ-014 RUN: reset_out_ high; sw_reset_req=1 -> HOLD on the next edge; else btn_s=0 -> DEBOUNCE, counter=1.
REQ-015 DEBOUNCE: reset_out_ stays high; btn_s=1 -> RUN, counter cleared; btn_s=0 increments counter; when counter reaches DEBOUNCE_CYCLES -> HOLD with cause=1.
REQ-016 sw_reset_req in DEBOUNCE SHALL win over the button: -> HOLD, cause=2.
REQ-017 sw_reset_req and button SHALL be ignored in POR, HOLD, WAIT_RELEASE (no re-trigger, no count).
REQ-018 HOLD: reset_out_ low from the entry edge for exactly HOLD_CYCLES edges; then -> RUN if btn_s=1, else WAIT_RELEASE.
REQ-019 WAIT_RELEASE: reset_out_ low; btn_s=1 -> RUN with reset_out_ high on the same edge.
REQ-020 On each HOLD entry, reset_cause SHALL update on the entry edge and reset_count SHALL increment, saturating at 255.
REQ-021 reset_out_ SHALL never glitch: registered only, no combinational path from any input.
REQ-022 Counter width SHALL be the minimum to hold max(POR_CYCLES, DEBOUNCE_CYCLES, HOLD_CYCLES); no wrap in any state.

Reset
REQ-023 reset_ low SHALL asynchronously force: state=POR, counter=0, btn_s flops=1 (released), reset_out_=0, reset_cause=0, reset_count=0.
REQ-024 reset_ asserted mid-DEBOUNCE/HOLD/WAIT_RELEASE SHALL abort the sequence immediately and restart the full POR sequence on release.

Structure
REQ-025 State encoding and cause codes (CAUSE_POR/BUTTON/SW) SHALL live in the shared package reset_pkg.
REQ-026 The button synchronizer SHALL be a separate sub-module sync_bit (2-flop, reset value parameterized to 1).
REQ-027 All counting SHALL use one shared counter, not one per state.

Verification (POR_CYCLES=8, DEBOUNCE_CYCLES=4, HOLD_CYCLES=5)
REQ-028 Release reset_ -> reset_out_ low for 7 edges, high on edge 8; reset_cause=0, reset_count=0.
REQ-029 button_ low for 2 cycles then high, in RUN -> reset_out_ stays high, reset_count stays 0.
REQ-030 button_ low 10 cycles -> reset_out_ low 2+4 edges after press, low for 5 edges, held until btn_s high, then high; cause=1, count=1.
REQ-031 sw_reset_req pulse in RUN -> reset_out_ low next edge for exactly 5 edges; cause=2; second pulse during HOLD ignored, count=1.
REQ-032 sw_reset_req in the same cycle the debounce completes -> cause=2, single HOLD, count+1 only.
REQ-033 reset_ pulse mid-HOLD -> reset_out_ low immediately without clk, cause=0, count=0, full 8-cycle POR on release.
